// File: rtl/mem_stage.sv
// Memory stage with MEM/WB pipeline register: drives the req/gnt/rvalid data bus,
// aligns load/store data and stalls upstream while a bus transaction is outstanding.
module mem_stage #(
    parameter int N = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_in,
    input  logic [4:0]      cw_mem,
    input  logic [2:0]      cw_wb_in,
    input  logic [N-1:0]    ALUres_in,
    input  logic [N-1:0]    store_data,
    input  logic [N-1:0]    NPCin,
    input  logic [5:0]      regDest_in,
    input  logic            flush,
    output logic            stall,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [N-1:0]    dmem_addr,
    output logic [N/8-1:0]  dmem_be,
    output logic [N-1:0]    dmem_wdata,
    input  logic            dmem_gnt,
    input  logic            dmem_rvalid,
    input  logic [N-1:0]    dmem_rdata,
    output logic [2:0]      cw_wb,
    output logic [N-1:0]    ALUres,
    output logic [N-1:0]    MEMread,
    output logic [N-1:0]    NPCout,
    output logic [5:0]      regDest_out,
    output logic            mem_err
);

    localparam int NB = N / 8;

    typedef enum logic [1:0] {IDLE, WAIT_GNT, WAIT_RV} state_t;

    state_t         state_q, state_d;
    logic           discard_q, discard_d;
    logic [2:0]     cw_wb_q;
    logic [N-1:0]   alures_q, memread_q, npc_q;
    logic [5:0]     regdest_q;
    logic           mem_err_q;

    logic           mem_rd, mem_wr;
    logic [2:0]     funct3;
    logic [1:0]     a_lo;
    logic           is_mem, f3_bad, misalign, acc_err, mem_ok;
    logic           req_c, stall_c, wb_take, ld_done, err_pulse;
    logic [7:0]     byte_sel;
    logic [15:0]    half_sel;
    logic [N-1:0]   ld_ext;

    assign mem_rd = cw_mem[0];
    assign mem_wr = cw_mem[1];
    assign funct3 = cw_mem[4:2];
    assign a_lo   = ALUres_in[1:0];

    // Stores only have signed-size encodings, so funct3[2] is illegal for them.
    assign f3_bad   = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111)
                      || (mem_wr && funct3[2]);
    assign misalign = ((funct3[1:0] == 2'b01) && a_lo[0])
                      || ((funct3[1:0] == 2'b10) && (a_lo != 2'b00));
    assign is_mem   = valid_in && (mem_rd || mem_wr);
    assign acc_err  = is_mem && ((mem_rd && mem_wr) || f3_bad || misalign);
    assign mem_ok   = is_mem && !acc_err;

    assign dmem_we   = mem_wr;
    assign dmem_addr = {ALUres_in[N-1:2], 2'b00};

    always_comb begin
        dmem_be = '1;
        case (funct3[1:0])
            2'b00:   dmem_be = NB'(1) << a_lo;
            2'b01:   dmem_be = NB'(3) << {a_lo[1], 1'b0};
            default: dmem_be = '1;
        endcase
    end

    for (genvar gi = 0; gi < NB; gi++) begin : g_lane
        assign dmem_wdata[8*gi +: 8] =
            (funct3[1:0] == 2'b00) ? store_data[7:0] :
            (funct3[1:0] == 2'b01) ? store_data[8*(gi%2) +: 8] :
                                     store_data[8*gi +: 8];
    end

    assign byte_sel = dmem_rdata[{a_lo, 3'b000} +: 8];
    assign half_sel = dmem_rdata[{a_lo[1], 4'b0000} +: 16];

    always_comb begin
        ld_ext = dmem_rdata;
        case (funct3)
            3'b000:  ld_ext = {{(N-8){byte_sel[7]}}, byte_sel};
            3'b100:  ld_ext = {{(N-8){1'b0}}, byte_sel};
            3'b001:  ld_ext = {{(N-16){half_sel[15]}}, half_sel};
            3'b101:  ld_ext = {{(N-16){1'b0}}, half_sel};
            default: ld_ext = dmem_rdata;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        discard_d = discard_q;
        req_c     = 1'b0;
        stall_c   = 1'b0;
        wb_take   = 1'b0;
        ld_done   = 1'b0;
        err_pulse = 1'b0;
        case (state_q)
            IDLE: begin
                discard_d = 1'b0;
                if (flush) begin
                    wb_take = 1'b0;
                end else if (acc_err) begin
                    err_pulse = 1'b1;
                end else if (mem_ok) begin
                    req_c = 1'b1;
                    if (!dmem_gnt) begin
                        state_d = WAIT_GNT;
                        stall_c = 1'b1;
                    end else if (mem_wr) begin
                        wb_take = 1'b1;
                    end else begin
                        state_d = WAIT_RV;
                        stall_c = 1'b1;
                    end
                end else begin
                    wb_take = valid_in;
                end
            end
            // A flush here cannot cancel the bus request; it only discards the result.
            WAIT_GNT: begin
                req_c = 1'b1;
                if (flush) discard_d = 1'b1;
                if (!dmem_gnt) begin
                    stall_c = 1'b1;
                end else if (mem_wr) begin
                    state_d = IDLE;
                    wb_take = !(discard_q || flush);
                end else begin
                    state_d = WAIT_RV;
                    stall_c = 1'b1;
                end
            end
            WAIT_RV: begin
                if (flush) discard_d = 1'b1;
                if (dmem_rvalid) begin
                    state_d = IDLE;
                    ld_done = 1'b1;
                    wb_take = !(discard_q || flush);
                end else begin
                    stall_c = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign dmem_req = req_c && !rst;
    assign stall    = stall_c && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            discard_q <= 1'b0;
            cw_wb_q   <= 3'b000;
            alures_q  <= '0;
            memread_q <= '0;
            npc_q     <= '0;
            regdest_q <= 6'd0;
            mem_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            discard_q <= discard_d;
            cw_wb_q   <= wb_take ? cw_wb_in : 3'b000;
            alures_q  <= ALUres_in;
            memread_q <= ld_done ? ld_ext : '0;
            npc_q     <= NPCin;
            regdest_q <= regDest_in;
            mem_err_q <= err_pulse;
        end
    end

    assign cw_wb       = cw_wb_q;
    assign ALUres      = alures_q;
    assign MEMread     = memread_q;
    assign NPCout      = npc_q;
    assign regDest_out = regdest_q;
    assign mem_err     = mem_err_q;

endmodule
